cpu_execute_stage: RTL and testbench

CPU_EXECUTE_STAGE -- requirements
Module: cpu_execute_stage

---
 rtl/cpu_execute_stage.sv | 172 +++++++++++++++++
 tb/tb_cpu_execute_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_execute_stage
//  Purpose  : Single-entry execute stage of an in-order pipeline. Selects the
//             operands, runs the ALU, resolves branches and holds the result
//             for the memory stage behind a valid/ready handshake.
//  Ports    : clk, reset            - rising-edge clock, sync active-high reset
//             in_valid / in_ready   - decode-side handshake
//             alu_op .. reg_dest    - decoded instruction fields and operands
//             wb_reg_write/dest/data- writeback bypass source
//             flush                 - kills held and incoming instruction
//             out_ready             - memory stage accepts the held entry
//             out_* , branch_*      - registered result entry
//  Options  : define CPU_EX_FORWARD_EN to enable operand forwarding and the
//             load-use interlock; otherwise operands pass through unmodified.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_execute_stage #(
    parameter int REG_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              alu_op,
    input  logic                    use_reg_b,
    input  logic                    branch,
    input  logic                    mem_write,
    input  logic                    mem_read,
    input  logic                    mem_to_reg,
    input  logic                    reg_write,
    input  logic [ADDR_WIDTH-1:0]   next_pc,
    input  logic [REG_WIDTH-1:0]    ra_data,
    input  logic [REG_WIDTH-1:0]    rb_data,
    input  logic [REG_WIDTH-1:0]    offset_data,
    input  logic [REG_ID_WIDTH-1:0] ra_id,
    input  logic [REG_ID_WIDTH-1:0] rb_id,
    input  logic [REG_ID_WIDTH-1:0] reg_dest,
    input  logic                    wb_reg_write,
    input  logic [REG_ID_WIDTH-1:0] wb_reg_dest,
    input  logic [REG_WIDTH-1:0]    wb_data,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [REG_WIDTH-1:0]    out_alu_result,
    output logic [REG_WIDTH-1:0]    out_store_data,
    output logic [REG_ID_WIDTH-1:0] out_reg_dest,
    output logic                    out_mem_read,
    output logic                    out_mem_write,
    output logic                    out_mem_to_reg,
    output logic                    out_reg_write,
    output logic                    branch_taken,
    output logic [ADDR_WIDTH-1:0]   branch_target
);

    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_XOR = 3'd4;
    localparam logic [2:0] c_ALU_SLL = 3'd5;
    localparam logic [2:0] c_ALU_SRL = 3'd6;
    localparam logic [2:0] c_ALU_SLT = 3'd7;

    logic [REG_WIDTH-1:0]  w_ra_op;
    logic [REG_WIDTH-1:0]  w_rb_op;
    logic [REG_WIDTH-1:0]  w_op_b;
    logic [REG_WIDTH-1:0]  w_alu;
    logic                  w_load_use_stall;
    logic                  w_accept;
    logic                  w_branch_taken;
    logic [ADDR_WIDTH-1:0] w_branch_target;

`ifdef CPU_EX_FORWARD_EN
    // The held entry can only bypass a non-load result; a load's data is not
    // known until the memory stage, which is what the interlock covers.
    logic w_held_fwd;
    assign w_held_fwd = out_valid && out_reg_write && !out_mem_read;

    always_comb begin
        w_ra_op = ra_data;
        if (ra_id != '0 && w_held_fwd && out_reg_dest == ra_id) begin
            w_ra_op = out_alu_result;
        end else if (ra_id != '0 && wb_reg_write && wb_reg_dest == ra_id) begin
            w_ra_op = wb_data;
        end
    end

    always_comb begin
        w_rb_op = rb_data;
        if (rb_id != '0 && w_held_fwd && out_reg_dest == rb_id) begin
            w_rb_op = out_alu_result;
        end else if (rb_id != '0 && wb_reg_write && wb_reg_dest == rb_id) begin
            w_rb_op = wb_data;
        end
    end

    // rb only matters when it feeds the ALU or is the store data.
    assign w_load_use_stall = out_valid && out_mem_read && (out_reg_dest != '0) &&
                              ((out_reg_dest == ra_id) ||
                               ((out_reg_dest == rb_id) && (use_reg_b || mem_write)));
`else
    logic w_unused;
    assign w_ra_op          = ra_data;
    assign w_rb_op          = rb_data;
    assign w_load_use_stall = 1'b0;
    assign w_unused         = ^{ra_id, rb_id, wb_reg_write, wb_reg_dest, wb_data};
`endif

    assign in_ready = !reset && (!out_valid || out_ready) && !w_load_use_stall && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_op_b   = use_reg_b ? w_rb_op : offset_data;

    always_comb begin
        w_alu = '0;
        case (alu_op)
            c_ALU_ADD: w_alu = w_ra_op + w_op_b;
            c_ALU_SUB: w_alu = w_ra_op - w_op_b;
            c_ALU_AND: w_alu = w_ra_op & w_op_b;
            c_ALU_OR:  w_alu = w_ra_op | w_op_b;
            c_ALU_XOR: w_alu = w_ra_op ^ w_op_b;
            c_ALU_SLL: w_alu = w_ra_op << w_op_b[4:0];
            c_ALU_SRL: w_alu = w_ra_op >> w_op_b[4:0];
            c_ALU_SLT: w_alu = {{(REG_WIDTH-1){1'b0}}, ($signed(w_ra_op) < $signed(w_op_b))};
            default:   w_alu = '0;
        endcase
    end

    assign w_branch_taken  = branch && (w_alu == '0);
    assign w_branch_target = next_pc + offset_data[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_alu_result <= '0;
            out_store_data <= '0;
            out_reg_dest   <= '0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_reg_write  <= 1'b0;
            branch_taken   <= 1'b0;
            branch_target  <= '0;
        end else if (flush) begin
            // Only the side-effecting controls need killing; the data fields
            // are don't-care once out_valid is low.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_mem_write <= 1'b0;
            branch_taken  <= 1'b0;
        end else if (w_accept) begin
            out_valid      <= 1'b1;
            out_alu_result <= w_alu;
            out_store_data <= w_rb_op;
            out_reg_dest   <= reg_dest;
            out_mem_read   <= mem_read;
            out_mem_write  <= mem_write;
            out_mem_to_reg <= mem_to_reg;
            out_reg_write  <= reg_write;
            branch_taken   <= w_branch_taken;
            branch_target  <= w_branch_target;
        end else if (!out_valid || out_ready) begin
            // Entry consumed (or empty) with nothing new: issue a bubble.
            out_valid    <= 1'b0;
            branch_taken <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_execute_stage
//  Purpose  : Self-checking bench for cpu_execute_stage: directed scenarios
//             followed by randomized traffic compared every cycle against a
//             behavioural model of the stage.
//  Options  : honours CPU_EX_FORWARD_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_execute_stage;

`ifdef CPU_EX_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_op;
    logic        use_reg_b, branch, mem_write, mem_read, mem_to_reg, reg_write;
    logic [31:0] next_pc, ra_data, rb_data, offset_data;
    logic [4:0]  ra_id, rb_id, reg_dest;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_dest;
    logic [31:0] wb_data;
    logic        flush, out_ready;
    logic        out_valid;
    logic [31:0] out_alu_result, out_store_data;
    logic [4:0]  out_reg_dest;
    logic        out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write;
    logic        branch_taken;
    logic [31:0] branch_target;

    cpu_execute_stage #(
        .REG_WIDTH    (32),
        .ADDR_WIDTH   (32),
        .REG_ID_WIDTH (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_op         (alu_op),
        .use_reg_b      (use_reg_b),
        .branch         (branch),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .next_pc        (next_pc),
        .ra_data        (ra_data),
        .rb_data        (rb_data),
        .offset_data    (offset_data),
        .ra_id          (ra_id),
        .rb_id          (rb_id),
        .reg_dest       (reg_dest),
        .wb_reg_write   (wb_reg_write),
        .wb_reg_dest    (wb_reg_dest),
        .wb_data        (wb_data),
        .flush          (flush),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_reg_dest   (out_reg_dest),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the held output entry.
    logic        m_valid = 1'b0, m_mr = 1'b0, m_mw = 1'b0, m_m2r = 1'b0, m_rw = 1'b0, m_bt = 1'b0;
    logic [31:0] m_res = '0, m_store = '0, m_btgt = '0;
    logic [4:0]  m_dest = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << (b % 32);
            3'd6:    return a >> (b % 32);
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] id, input logic [31:0] data);
        if (c_FWD && id != 0 && m_valid && m_rw && !m_mr && m_dest == id) return m_res;
        if (c_FWD && id != 0 && wb_reg_write && wb_reg_dest == id) return wb_data;
        return data;
    endfunction

    function automatic logic stall_ref();
        return c_FWD && m_valid && m_mr && m_dest != 0 &&
               (m_dest == ra_id || (m_dest == rb_id && (use_reg_b || mem_write)));
    endfunction

    function automatic logic ready_ref();
        return !reset && (!m_valid || out_ready) && !stall_ref() && !flush;
    endfunction

    task automatic model_step();
        logic        rdy;
        logic [31:0] a, rb, r;
        rdy = ready_ref();
        a   = opnd(ra_id, ra_data);
        rb  = opnd(rb_id, rb_data);
        r   = alu_ref(alu_op, a, use_reg_b ? rb : offset_data);
        if (reset) begin
            m_valid = 0; m_res = 0; m_store = 0; m_dest = 0; m_mr = 0;
            m_mw = 0; m_m2r = 0; m_rw = 0; m_bt = 0; m_btgt = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_mw = 0; m_bt = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1; m_res = r; m_store = rb; m_dest = reg_dest;
            m_mr = mem_read; m_mw = mem_write; m_m2r = mem_to_reg; m_rw = reg_write;
            m_bt = branch && (r == 0);
            m_btgt = next_pc + offset_data;
        end else if (!m_valid || out_ready) begin
            m_valid = 0; m_bt = 0;
        end
    endtask

    // One clock: check in_ready with inputs settled, clock, check the entry.
    task automatic cycle();
        #1;
        chk("in_ready", in_ready, ready_ref());
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_alu_result", out_alu_result, m_res);
        chk("out_store_data", out_store_data, m_store);
        chk("out_reg_dest", out_reg_dest, m_dest);
        chk("out_mem_read", out_mem_read, m_mr);
        chk("out_mem_write", out_mem_write, m_mw);
        chk("out_mem_to_reg", out_mem_to_reg, m_m2r);
        chk("out_reg_write", out_reg_write, m_rw);
        chk("branch_taken", branch_taken, m_bt);
        chk("branch_target", branch_target, m_btgt);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [31:0] ra, input logic [31:0] rb,
                             input logic [31:0] off, input logic [4:0] raid, input logic [4:0] rbid,
                             input logic [4:0] dest, input logic ub, input logic br, input logic mr,
                             input logic mw, input logic rw, input logic [31:0] npc);
        in_valid = 1; alu_op = op; ra_data = ra; rb_data = rb; offset_data = off;
        ra_id = raid; rb_id = rbid; reg_dest = dest; use_reg_b = ub; branch = br;
        mem_read = mr; mem_write = mw; mem_to_reg = mr; reg_write = rw; next_pc = npc;
    endtask

    initial begin
        reset = 1; in_valid = 0; alu_op = 0; use_reg_b = 0; branch = 0; mem_write = 0;
        mem_read = 0; mem_to_reg = 0; reg_write = 0; next_pc = 0; ra_data = 0; rb_data = 0;
        offset_data = 0; ra_id = 0; rb_id = 0; reg_dest = 0; wb_reg_write = 0;
        wb_reg_dest = 0; wb_data = 0; flush = 0; out_ready = 1;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_out_valid", out_valid, 1'b0);
        reset = 0;

        // ADD r3 = 5 + 7
        set_instr(3'd0, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 32'd0);
        cycle();
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", out_alu_result, 32'd12);
        chk("add_dest", out_reg_dest, 5'd3);

        // SUB r4 = r3 - r1 with stale r3 operand
        set_instr(3'd1, 32'd0, 32'd5, 32'd0, 5'd3, 5'd1, 5'd4, 1, 0, 0, 0, 1, 32'd0);
        cycle();
        chk("fwd_sub_result", out_alu_result, c_FWD ? 32'd7 : 32'hFFFF_FFFB);

        // Load r2, then a consumer of r2
        set_instr(3'd0, 32'd100, 32'd0, 32'd0, 5'd1, 5'd0, 5'd2, 0, 0, 1, 0, 1, 32'd0);
        cycle();
        set_instr(3'd0, 32'd0, 32'd0, 32'd0, 5'd2, 5'd0, 5'd5, 0, 0, 0, 0, 1, 32'd0);
        #1 chk("load_use_in_ready", in_ready, !c_FWD);
        cycle();
        chk("load_use_bubble", out_valid, !c_FWD);
        wb_reg_write = 1; wb_reg_dest = 5'd2; wb_data = 32'd9;
        cycle();
        chk("load_use_wb_result", out_alu_result, c_FWD ? 32'd9 : 32'd0);
        wb_reg_write = 0;

        // Branches: equal operands taken, unequal not taken
        set_instr(3'd1, 32'd4, 32'd4, 32'h20, 5'd6, 5'd7, 5'd0, 1, 1, 0, 0, 0, 32'h100);
        cycle();
        chk("branch_taken_eq", branch_taken, 1'b1);
        chk("branch_target", branch_target, 32'h120);
        rb_data = 32'd5;
        cycle();
        chk("branch_taken_ne", branch_taken, 1'b0);

        // Backpressure hold for three cycles, then flush
        set_instr(3'd0, 32'd1, 32'd1, 32'd0, 5'd6, 5'd7, 5'd8, 1, 0, 0, 0, 1, 32'd0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_in_ready", in_ready, 1'b0);
            cycle();
            chk("hold_result", out_alu_result, 32'hFFFF_FFFF);
        end
        flush = 1;
        cycle();
        chk("flush_valid", out_valid, 1'b0);
        flush = 0; out_ready = 1;

        // Reset in the middle of traffic
        cycle();
        chk("pre_reset_valid", out_valid, 1'b1);
        reset = 1;
        #1 chk("reset_in_ready", in_ready, 1'b0);
        cycle();
        chk("mid_reset_valid", out_valid, 1'b0);
        chk("mid_reset_result", out_alu_result, 32'd0);
        reset = 0;

        // Randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 600; n++) begin
            in_valid     = ($urandom % 4) != 0;
            alu_op       = 3'($urandom % 8);
            ra_id        = 5'($urandom % 4);
            rb_id        = 5'($urandom % 4);
            reg_dest     = 5'($urandom % 4);
            use_reg_b    = $urandom % 2;
            branch       = ($urandom % 4) == 0;
            mem_read     = ($urandom % 4) == 0;
            mem_to_reg   = mem_read;
            mem_write    = ($urandom % 5) == 0;
            reg_write    = $urandom % 2;
            ra_data      = (($urandom % 2) != 0) ? 32'($urandom % 16) : $urandom;
            rb_data      = (($urandom % 3) == 0) ? ra_data : $urandom;
            offset_data  = (($urandom % 2) != 0) ? 32'($urandom % 64) : $urandom;
            next_pc      = $urandom;
            wb_reg_write = $urandom % 2;
            wb_reg_dest  = 5'($urandom % 4);
            wb_data      = $urandom;
            out_ready    = ($urandom % 4) != 0;
            flush        = ($urandom % 16) == 0;
            reset        = ($urandom % 64) == 0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
